// File: rtl/alu_result_stage.sv
// alu_result_stage
// Two-entry registered buffer between the ALU and writeback. Holds each ALU
// result with its destination tag, owns the architectural HI register (loaded
// only when a divide retires) and pulses br_taken when a compare with NZ set
// retires.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1 at that edge. in_ready is simply "not full" and never looks at
// out_ready, so there is no combinational path from writeback back to the ALU.
// flush wins over both handshakes in the cycle it is asserted.
module alu_result_stage #(
  parameter int DEPTH = 2,
  parameter int RD_W  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_aluop,
  input  logic [15:0]     in_lo,
  input  logic [15:0]     in_hi,
  input  logic            in_nz,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_wen,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     out_data,
  output logic [RD_W-1:0] out_rd,
  output logic            out_wen,
  output logic [15:0]     hi_reg,
  output logic            br_taken
);

  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

  // Entry storage, one array per field
  logic [3:0]      r_aluop [DEPTH];
  logic [15:0]     r_lo    [DEPTH];
  logic [15:0]     r_hi    [DEPTH];
  logic            r_nz    [DEPTH];
  logic [RD_W-1:0] r_rd    [DEPTH];
  logic            r_wen   [DEPTH];

  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic [1:0]      r_count;
  logic [15:0]     r_hi_reg;

  logic            w_push;
  logic            w_pop;
  logic [3:0]      w_head_op;

  // Handshake qualification; flush suppresses both transfers
  always_comb begin
    in_ready  = (r_count != FULL_COUNT);
    out_valid = (r_count != 2'd0);
    w_push    = in_valid & in_ready & ~flush;
    w_pop     = out_valid & out_ready & ~flush;
    w_head_op = r_aluop[r_rd_ptr];
  end

  // Entry write at the tail; fields of dropped pushes are never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_aluop[i] <= 4'h0;
        r_lo[i]    <= 16'h0000;
        r_hi[i]    <= 16'h0000;
        r_nz[i]    <= 1'b0;
        r_rd[i]    <= '0;
        r_wen[i]   <= 1'b0;
      end
    end else if (w_push) begin
      r_aluop[r_wr_ptr] <= in_aluop;
      r_lo[r_wr_ptr]    <= in_lo;
      r_hi[r_wr_ptr]    <= in_hi;
      r_nz[r_wr_ptr]    <= in_nz;
      r_rd[r_wr_ptr]    <= in_rd;
      r_wen[r_wr_ptr]   <= in_wen;
    end
  end

  // Pointer and occupancy bookkeeping; 1-bit pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Architectural HI: only a retiring divide may change it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi_reg <= 16'h0000;
    end else if (w_pop && (w_head_op == OP_DIV)) begin
      r_hi_reg <= r_hi[r_rd_ptr];
    end
  end

  // Head presentation; a compare never writes a register
  always_comb begin
    out_data = r_lo[r_rd_ptr];
    out_rd   = r_rd[r_rd_ptr];
    out_wen  = r_wen[r_rd_ptr] & (w_head_op != OP_CMP);
    hi_reg   = r_hi_reg;
    br_taken = w_pop & (w_head_op == OP_CMP) & r_nz[r_rd_ptr];
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios followed by random traffic,
// checked by a negedge monitor against a queue-based model of the buffer.
module tb_alu_result_stage;

  localparam int RD_W = 3;
  localparam int EW = 41; // {op[40:37], lo[36:21], hi[20:5], nz[4], rd[3:1], wen[0]}

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_aluop;
  logic [15:0]     in_lo;
  logic [15:0]     in_hi;
  logic            in_nz;
  logic [RD_W-1:0] in_rd;
  logic            in_wen;
  logic            out_valid;
  logic            out_ready;
  logic [15:0]     out_data;
  logic [RD_W-1:0] out_rd;
  logic            out_wen;
  logic [15:0]     hi_reg;
  logic            br_taken;

  int compared;
  int mismatched;

  logic [EW-1:0] exp_q[$];
  logic [15:0]   hi_model;

  alu_result_stage #(.DEPTH(2), .RD_W(RD_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_aluop(in_aluop),
    .in_lo(in_lo), .in_hi(in_hi), .in_nz(in_nz), .in_rd(in_rd), .in_wen(in_wen),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_wen(out_wen), .hi_reg(hi_reg), .br_taken(br_taken)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- helpers ----------------
  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- monitor / scoreboard ----------------
  // Sampled mid-cycle: checks what the DUT shows now, then advances the model
  // by what the coming rising edge will do.
  always @(negedge clk) begin
    logic [EW-1:0] head;
    logic          exp_br;
    logic          can_push;
    if (!rst_n) begin
      exp_q.delete();
      hi_model = 16'h0000;
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_hi_reg", {16'b0, hi_reg}, 32'd0);
      check("rst_br_taken", {31'b0, br_taken}, 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    end else begin
      check("in_ready", {31'b0, in_ready}, {31'b0, exp_q.size() < 2});
      check("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() > 0});
      check("hi_reg", {16'b0, hi_reg}, {16'b0, hi_model});
      exp_br = 1'b0;
      can_push = exp_q.size() < 2;
      if (exp_q.size() > 0 && out_ready && !flush) begin
        head = exp_q[0];
        check("out_data", {16'b0, out_data}, {16'b0, head[36:21]});
        check("out_rd", {29'b0, out_rd}, {29'b0, head[3:1]});
        check("out_wen", {31'b0, out_wen}, {31'b0, head[0] && head[40:37] != 4'b1010});
        exp_br = (head[40:37] == 4'b1010) && head[4];
      end
      check("br_taken", {31'b0, br_taken}, {31'b0, exp_br});
      if (flush) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() > 0 && out_ready) begin
          head = exp_q.pop_front();
          if (head[40:37] == 4'b0011) hi_model = head[20:5];
        end
        if (in_valid && can_push)
          exp_q.push_back({in_aluop, in_lo, in_hi, in_nz, in_rd, in_wen});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_one(input logic [3:0] op, input logic [15:0] lo,
                          input logic [15:0] hi, input logic nz,
                          input logic [RD_W-1:0] rd, input logic wen);
    logic ok;
    in_valid = 1'b1;
    in_aluop = op; in_lo = lo; in_hi = hi; in_nz = nz; in_rd = rd; in_wen = wen;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = in_ready && !flush;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL push_timeout: got no accept expected accept within 20 cycles");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic held_ready;
    logic [3:0] ops [4];
    ops[0] = 4'b0000; ops[1] = 4'b0011; ops[2] = 4'b1010; ops[3] = 4'b0101;
    compared = 0; mismatched = 0; hi_model = 16'h0000;
    flush = 0; in_valid = 0; out_ready = 0;
    in_aluop = 0; in_lo = 0; in_hi = 0; in_nz = 0; in_rd = 0; in_wen = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // basic flow
    out_ready = 1;
    push_one(4'b0000, 16'h1234, 16'h0000, 1'b0, 3'd3, 1'b1);
    idle(2);

    // backpressure: third push held until a slot frees
    out_ready = 0;
    push_one(4'b0000, 16'd1, 16'd0, 1'b0, 3'd1, 1'b1);
    push_one(4'b0000, 16'd2, 16'd0, 1'b0, 3'd2, 1'b1);
    fork
      push_one(4'b0000, 16'd3, 16'd0, 1'b0, 3'd4, 1'b1);
      begin idle(3); out_ready = 1; end
    join
    idle(3);

    // divide retire updates HI only at the pop edge
    out_ready = 0;
    push_one(4'b0011, 16'd7, 16'd2, 1'b0, 3'd5, 1'b1);
    idle(3);
    out_ready = 1;
    idle(2);

    // compare: taken then not taken
    push_one(4'b1010, 16'd0, 16'd0, 1'b1, 3'd6, 1'b1);
    push_one(4'b1010, 16'd0, 16'd0, 1'b0, 3'd7, 1'b1);
    idle(2);

    // flush beats push and pop; HI unchanged
    out_ready = 0;
    push_one(4'b0011, 16'd11, 16'hBEEF, 1'b0, 3'd1, 1'b1);
    push_one(4'b0000, 16'd12, 16'd0, 1'b0, 3'd2, 1'b1);
    flush = 1; in_valid = 1; out_ready = 1;
    in_aluop = 4'b0000; in_lo = 16'd13; in_hi = 0; in_nz = 0; in_rd = 3'd3; in_wen = 1;
    idle(1);
    flush = 0; in_valid = 0;
    idle(2);

    // async reset mid-stream with a taken compare at the head
    push_one(4'b0011, 16'd1, 16'h00FF, 1'b0, 3'd1, 1'b1);
    idle(2);
    out_ready = 0;
    push_one(4'b1010, 16'd0, 16'd0, 1'b1, 3'd2, 1'b1);
    check("pre_reset_hi", {16'b0, hi_reg}, 32'h00FF);
    out_ready = 1;
    #1 rst_n = 1'b0;
    #1;
    check("async_out_valid", {31'b0, out_valid}, 32'd0);
    check("async_hi_reg", {16'b0, hi_reg}, 32'd0);
    check("async_br_taken", {31'b0, br_taken}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // random traffic, holding a stalled input stable
    held_ready = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (!(in_valid && !held_ready)) begin
        in_valid = $urandom_range(0, 1);
        in_aluop = ops[$urandom_range(0, 3)];
        in_lo = 16'($urandom); in_hi = 16'($urandom);
        in_nz = $urandom_range(0, 1); in_rd = 3'($urandom); in_wen = $urandom_range(0, 1);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 24) == 0);
      @(negedge clk);
      held_ready = in_ready || flush;
      @(posedge clk);
      #1;
    end
    in_valid = 0; flush = 0; out_ready = 1;
    idle(4);
    check("drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
